// File: rtl/alu_operand_collector.sv
// alu_operand_collector: issue stage in front of the registered N-bit ALU.
// Collects operand beats (A and B may arrive separately), merges them for one
// command and issues a single-cycle ce-qualified request. If an operand is still
// missing after TIMEOUT cycles, it issues the partial request and flags timeout_err.
// Optional feature macro: ALU_CMD_CHECK_EN (reject illegal commands, pulse cmd_err).
module alu_operand_collector #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic         s_mode,
    input  logic [3:0]   s_cmd,
    input  logic         s_cin,
    input  logic [1:0]   s_sel,
    input  logic [N-1:0] s_opa,
    input  logic [N-1:0] s_opb,
    output logic         alu_ce,
    output logic         alu_mode,
    output logic [3:0]   alu_cmd,
    output logic         alu_cin,
    output logic [1:0]   alu_inp_valid,
    output logic [N-1:0] alu_opa,
    output logic [N-1:0] alu_opb,
    output logic         busy,
    output logic         timeout_err,
    output logic         cmd_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ISSUE} state_t;

    state_t         r_state, w_state_n;
    logic           r_mode, w_mode_n;
    logic [3:0]     r_cmd, w_cmd_n;
    logic           r_cin, w_cin_n;
    logic [1:0]     r_got, w_got_n;
    logic [N-1:0]   r_a, w_a_n, r_b, w_b_n;
    logic [TW-1:0]  r_timer, w_timer_n;
    logic           r_to, w_to_n;

    logic           r_alu_ce, w_alu_ce_n;
    logic           r_alu_mode, w_alu_mode_n;
    logic [3:0]     r_alu_cmd, w_alu_cmd_n;
    logic           r_alu_cin, w_alu_cin_n;
    logic [1:0]     r_alu_iv, w_alu_iv_n;
    logic [N-1:0]   r_alu_opa, w_alu_opa_n, r_alu_opb, w_alu_opb_n;
    logic           r_busy, w_busy_n;
    logic           r_terr, w_terr_n;
    logic           r_cerr, w_cerr_n;

    logic           w_accept;
    logic [1:0]     w_need_in, w_need_hold, w_got_merge;
    logic           w_illegal;

    function automatic logic [1:0] f_need(input logic mode, input logic [3:0] cmd);
        logic [1:0] n;
        n = 2'b11;
        if (mode) begin
            case (cmd)
                4'd4, 4'd5: n = 2'b01;
                4'd6, 4'd7: n = 2'b10;
                default:    n = 2'b11;
            endcase
        end else begin
            case (cmd)
                4'd6, 4'd8,  4'd10: n = 2'b01;
                4'd7, 4'd9,  4'd11: n = 2'b10;
                default:            n = 2'b11;
            endcase
        end
        return n;
    endfunction

    // s_ready is decoded from the state register and forced low while rst is held
    assign s_ready = (r_state != S_ISSUE) && !rst;

    // Next-state, operand merge and registered-output next values
    always_comb begin
        w_accept     = s_valid & s_ready;
        w_need_in    = f_need(s_mode, s_cmd);
        w_need_hold  = f_need(r_mode, r_cmd);
        w_got_merge  = r_got | (w_accept ? s_sel : 2'b00);
`ifdef ALU_CMD_CHECK_EN
        w_illegal    = s_mode ? (s_cmd > 4'd12) : (s_cmd > 4'd13);
`else
        w_illegal    = 1'b0;
`endif
        w_state_n    = r_state;
        w_mode_n     = r_mode;
        w_cmd_n      = r_cmd;
        w_cin_n      = r_cin;
        w_got_n      = r_got;
        w_a_n        = r_a;
        w_b_n        = r_b;
        w_timer_n    = r_timer;
        w_to_n       = r_to;
        w_alu_ce_n   = 1'b0;
        w_alu_mode_n = r_alu_mode;
        w_alu_cmd_n  = r_alu_cmd;
        w_alu_cin_n  = r_alu_cin;
        w_alu_iv_n   = r_alu_iv;
        w_alu_opa_n  = r_alu_opa;
        w_alu_opb_n  = r_alu_opb;
        w_terr_n     = 1'b0;
        w_cerr_n     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept && (s_sel != 2'b00)) begin
                    if (w_illegal) begin
                        w_cerr_n = 1'b1;
                    end else begin
                        w_mode_n  = s_mode;
                        w_cmd_n   = s_cmd;
                        w_cin_n   = s_cin;
                        w_got_n   = s_sel;
                        w_a_n     = s_sel[0] ? s_opa : '0;
                        w_b_n     = s_sel[1] ? s_opb : '0;
                        w_timer_n = '0;
                        w_to_n    = 1'b0;
                        w_state_n = ((s_sel & w_need_in) == w_need_in) ? S_ISSUE : S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                w_got_n = w_got_merge;
                if (w_accept && s_sel[0]) w_a_n = s_opa;
                if (w_accept && s_sel[1]) w_b_n = s_opb;
                // A completing beat takes priority over an expiring timer
                if ((w_got_merge & w_need_hold) == w_need_hold) begin
                    w_state_n = S_ISSUE;
                end else if (r_timer == TLAST) begin
                    w_state_n = S_ISSUE;
                    w_to_n    = 1'b1;
                end else begin
                    w_timer_n = r_timer + TW'(1);
                end
            end
            S_ISSUE: begin
                w_alu_ce_n   = 1'b1;
                w_alu_mode_n = r_mode;
                w_alu_cmd_n  = r_cmd;
                w_alu_cin_n  = r_cin;
                w_alu_iv_n   = r_got;
                w_alu_opa_n  = r_got[0] ? r_a : '0;
                w_alu_opb_n  = r_got[1] ? r_b : '0;
                w_terr_n     = r_to;
                w_got_n      = 2'b00;
                w_to_n       = 1'b0;
                w_state_n    = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase

        w_busy_n = (w_state_n != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_cmd      <= '0;
            r_cin      <= 1'b0;
            r_got      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_timer    <= '0;
            r_to       <= 1'b0;
            r_alu_ce   <= 1'b0;
            r_alu_mode <= 1'b0;
            r_alu_cmd  <= '0;
            r_alu_cin  <= 1'b0;
            r_alu_iv   <= '0;
            r_alu_opa  <= '0;
            r_alu_opb  <= '0;
            r_busy     <= 1'b0;
            r_terr     <= 1'b0;
            r_cerr     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_mode     <= w_mode_n;
            r_cmd      <= w_cmd_n;
            r_cin      <= w_cin_n;
            r_got      <= w_got_n;
            r_a        <= w_a_n;
            r_b        <= w_b_n;
            r_timer    <= w_timer_n;
            r_to       <= w_to_n;
            r_alu_ce   <= w_alu_ce_n;
            r_alu_mode <= w_alu_mode_n;
            r_alu_cmd  <= w_alu_cmd_n;
            r_alu_cin  <= w_alu_cin_n;
            r_alu_iv   <= w_alu_iv_n;
            r_alu_opa  <= w_alu_opa_n;
            r_alu_opb  <= w_alu_opb_n;
            r_busy     <= w_busy_n;
            r_terr     <= w_terr_n;
            r_cerr     <= w_cerr_n;
        end
    end

    assign alu_ce        = r_alu_ce;
    assign alu_mode      = r_alu_mode;
    assign alu_cmd       = r_alu_cmd;
    assign alu_cin       = r_alu_cin;
    assign alu_inp_valid = r_alu_iv;
    assign alu_opa       = r_alu_opa;
    assign alu_opb       = r_alu_opb;
    assign busy          = r_busy;
    assign timeout_err   = r_terr;
    assign cmd_err       = r_cerr;

endmodule

// File: tb/tb_alu_operand_collector.sv
// Testbench for alu_operand_collector: scenario tasks plus randomized transactions
// checked against a transaction-level model of the collection rules.
module tb_alu_operand_collector;
    localparam int N  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid, s_ready, s_mode, s_cin;
    logic [3:0]   s_cmd;
    logic [1:0]   s_sel;
    logic [N-1:0] s_opa, s_opb;
    logic         alu_ce, alu_mode, alu_cin, busy, timeout_err, cmd_err;
    logic [3:0]   alu_cmd;
    logic [1:0]   alu_inp_valid;
    logic [N-1:0] alu_opa, alu_opb;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    alu_operand_collector #(.N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_mode(s_mode), .s_cmd(s_cmd), .s_cin(s_cin), .s_sel(s_sel),
        .s_opa(s_opa), .s_opb(s_opb), .alu_ce(alu_ce), .alu_mode(alu_mode),
        .alu_cmd(alu_cmd), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .busy(busy),
        .timeout_err(timeout_err), .cmd_err(cmd_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           c;
        logic         m;
        logic [3:0]   cmd;
        logic         cin;
        logic [1:0]   iv;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         te;
        logic         bsy;
    } iss_t;
    iss_t q[$];

    // Record every issue strobe seen on the falling edge
    always @(negedge clk) begin
        if (alu_ce === 1'b1)
            q.push_back('{cyc, alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb, timeout_err, busy});
    end

    function automatic logic [1:0] need_of(input logic m, input logic [3:0] c);
        if (m) begin
            if (c == 4 || c == 5) return 2'b01;
            if (c == 6 || c == 7) return 2'b10;
            return 2'b11;
        end
        if (c == 6 || c == 8 || c == 10) return 2'b01;
        if (c == 7 || c == 9 || c == 11) return 2'b10;
        return 2'b11;
    endfunction

    // Present one beat from a falling edge; returns the cycle index of its acceptance
    task automatic send(input logic m, input logic [3:0] c, input logic ci, input logic [1:0] sel,
                        input logic [N-1:0] a, input logic [N-1:0] b, output int acc);
        s_mode = m; s_cmd = c; s_cin = ci; s_sel = sel; s_opa = a; s_opb = b; s_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (s_ready === 1'b1) break;
            @(negedge clk);
        end
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: s_ready=%b required 1", s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        s_valid = 1'b0;
    endtask

    // One command: first beat, optional second beat after d idle cycles (d<0: none)
    task automatic run_txn(input logic m, input logic [3:0] c, input logic ci,
                           input logic [1:0] sel1, input logic [N-1:0] a1, input logic [N-1:0] b1,
                           input int d, input logic [1:0] sel2, input logic [N-1:0] a2, input logic [N-1:0] b2);
        logic [1:0]   need, got;
        logic [N-1:0] ea, eb;
        logic         ete;
        int           acc1, acc2, exp_c;
        bit           found;
        iss_t         r;
        need = need_of(m, c);
        got  = sel1;
        ea   = sel1[0] ? a1 : '0;
        eb   = sel1[1] ? b1 : '0;
        acc2 = 0;
        send(m, c, ci, sel1, a1, b1, acc1);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL busy_after_accept: busy=%b required 1", busy);
        end
        if ((sel1 & need) == need) begin
            exp_c = acc1 + 1; ete = 1'b0;
        end else begin
            if (d >= 0) begin
                repeat (d) @(negedge clk);
                send(m, c, ci, sel2, a2, b2, acc2);
                got = got | sel2;
                if (sel2[0]) ea = a2;
                if (sel2[1]) eb = b2;
            end
            if ((got & need) == need) begin
                exp_c = acc2 + 1; ete = 1'b0;
            end else begin
                exp_c = acc1 + TO + 1; ete = 1'b1;
            end
        end
        found = 0;
        for (int k = 0; k < 3 * TO + 8; k++) begin
            if (q.size() != 0) begin found = 1; break; end
            @(posedge clk); #2;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL issue_wait: no alu_ce seen, required one at cycle %0d", exp_c);
            @(negedge clk);
            return;
        end
        r = q.pop_front();
        n_tests++;
        if (r.c !== exp_c) begin n_fail++; $display("FAIL issue_cycle: got %0d required %0d", r.c, exp_c); end
        n_tests++;
        if ({r.m, r.cmd, r.cin} !== {m, c, ci}) begin
            n_fail++; $display("FAIL issue_ctl: mode/cmd/cin=%b/%0d/%b required %b/%0d/%b", r.m, r.cmd, r.cin, m, c, ci);
        end
        n_tests++;
        if (r.iv !== got) begin n_fail++; $display("FAIL inp_valid: got %b required %b", r.iv, got); end
        n_tests++;
        if (r.a !== ea || r.b !== eb) begin
            n_fail++; $display("FAIL operands: opa=%h opb=%h required %h %h", r.a, r.b, ea, eb);
        end
        n_tests++;
        if (r.te !== ete) begin n_fail++; $display("FAIL timeout_err: got %b required %b", r.te, ete); end
        n_tests++;
        if (r.bsy !== 1'b0) begin n_fail++; $display("FAIL busy_at_issue: got %b required 0", r.bsy); end
        @(negedge clk);
        n_tests++;
        if (alu_ce !== 1'b0 || alu_opa !== ea || alu_opb !== eb || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_after_issue: ce=%b opa=%h opb=%h te=%b required 0 %h %h 0", alu_ce, alu_opa, alu_opb, timeout_err, ea, eb);
        end
        n_tests++;
        if (q.size() != 0) begin n_fail++; $display("FAIL extra_issue: %0d extra strobes required 0", q.size()); q.delete(); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({s_ready, alu_ce, alu_mode, alu_cmd, alu_cin, alu_inp_valid, alu_opa, alu_opb, busy, timeout_err, cmd_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b ce=%b iv=%b opa=%h opb=%h busy=%b required all 0", s_ready, alu_ce, alu_inp_valid, alu_opa, alu_opb, busy);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b required 1", s_ready); end
        @(negedge clk);
        q.delete();
    endtask

    task automatic test_spec_cases();
        run_txn(1'b1, 4'd0, 1'b0, 2'b11, 8'h12, 8'h34, -1, 2'b00, 8'h00, 8'h00);
        run_txn(1'b0, 4'd4, 1'b0, 2'b01, 8'hAA, 8'h00, 2, 2'b10, 8'h00, 8'h55);
        run_txn(1'b1, 4'd0, 1'b1, 2'b01, N'($urandom), N'($urandom), -1, 2'b00, 8'h00, 8'h00);
        run_txn(1'b1, 4'd6, 1'b0, 2'b10, N'($urandom), 8'hFF, -1, 2'b00, 8'h00, 8'h00);
        run_txn(1'b1, 4'd0, 1'b0, 2'b01, N'($urandom), 8'h00, TO - 1, 2'b10, 8'h00, N'($urandom));
    endtask

    task automatic test_reset_mid();
        int acc;
        send(1'b1, 4'd0, 1'b0, 2'b01, 8'h5A, 8'h00, acc);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({s_ready, alu_ce, alu_inp_valid, alu_opa, alu_opb, busy, timeout_err, cmd_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: ready=%b ce=%b iv=%b opa=%h busy=%b required all 0", s_ready, alu_ce, alu_inp_valid, alu_opa, busy);
        end
        rst = 1'b0;
        repeat (TO + 4) @(negedge clk);
        n_tests++;
        if (q.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_no_issue: strobes=%0d busy=%b required 0 0", q.size(), busy);
            q.delete();
        end
    endtask

    task automatic test_null_beat();
        s_sel = 2'b00; s_valid = 1'b1; s_mode = 1'b1; s_cmd = 4'd0;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || s_ready !== 1'b1 || q.size() != 0) begin
            n_fail++; $display("FAIL null_beat: busy=%b ready=%b strobes=%0d required 0 1 0", busy, s_ready, q.size());
            q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int acc1, acc2;
        iss_t r1, r2;
        s_mode = 1'b1; s_cmd = 4'd1; s_cin = 1'b0; s_sel = 2'b11; s_opa = 8'h11; s_opb = 8'h22; s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        acc1 = cyc;
        n_tests++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_issue: got %b required 0", s_ready); end
        s_cmd = 4'd2; s_opa = 8'h33; s_opb = 8'h44;
        acc2 = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            if (s_ready === 1'b1) begin
                @(negedge clk);
                acc2 = cyc;
                break;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        n_tests++;
        if (acc2 != acc1 + 2) begin n_fail++; $display("FAIL b2b_accept: second beat at %0d required %0d", acc2, acc1 + 2); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: %0d strobes required 2", q.size());
            q.delete();
        end else begin
            r1 = q.pop_front();
            r2 = q.pop_front();
            n_tests++;
            if (r1.c != acc1 + 1 || r1.cmd !== 4'd1 || r1.a !== 8'h11 || r1.b !== 8'h22) begin
                n_fail++; $display("FAIL b2b_first: cyc=%0d cmd=%0d a=%h b=%h required %0d 1 11 22", r1.c, r1.cmd, r1.a, r1.b, acc1 + 1);
            end
            n_tests++;
            if (r2.c != acc2 + 1 || r2.cmd !== 4'd2 || r2.a !== 8'h33 || r2.b !== 8'h44) begin
                n_fail++; $display("FAIL b2b_second: cyc=%0d cmd=%0d a=%h b=%h required %0d 2 33 44", r2.c, r2.cmd, r2.a, r2.b, acc2 + 1);
            end
        end
    endtask

    task automatic test_cmd_check();
`ifdef ALU_CMD_CHECK_EN
        int acc;
        send(1'b0, 4'd14, 1'b0, 2'b11, 8'h01, 8'h02, acc);
        n_tests++;
        if (cmd_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cmd_err_pulse: cmd_err=%b busy=%b required 1 0", cmd_err, busy);
        end
        @(negedge clk);
        n_tests++;
        if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL cmd_err_width: got %b required 0", cmd_err); end
        repeat (TO) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin n_fail++; $display("FAIL cmd_rejected: %0d strobes required 0", q.size()); q.delete(); end
`else
        run_txn(1'b0, 4'd14, 1'b0, 2'b11, 8'h01, 8'h02, -1, 2'b00, 8'h00, 8'h00);
        n_tests++;
        if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL cmd_err_tied: got %b required 0", cmd_err); end
`endif
    endtask

    task automatic test_random();
        logic       m;
        logic [3:0] c;
        logic [1:0] s1, s2;
        int         d;
        for (int i = 0; i < 30; i++) begin
            m  = 1'($urandom);
            c  = m ? 4'($urandom_range(0, 12)) : 4'($urandom_range(0, 13));
            s1 = 2'($urandom_range(1, 3));
            s2 = 2'($urandom_range(1, 3));
            d  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            run_txn(m, c, 1'($urandom), s1, N'($urandom), N'($urandom), d, s2, N'($urandom), N'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_mode = 1'b0; s_cmd = '0; s_cin = 1'b0;
        s_sel = '0; s_opa = '0; s_opb = '0;
        @(negedge clk);
        test_reset();
        test_spec_cases();
        test_reset_mid();
        test_null_beat();
        test_back_to_back();
        test_cmd_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
